// File: rtl/dm_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PIPE_BUSY = 2'd1,
    HOST_BUSY = 2'd2
  } dmState_e;

  localparam int unsigned DM_DATA_WIDTH     = 16;
  localparam int unsigned DM_ADDR_WIDTH     = 8;
  localparam int unsigned DM_PIPE_BURST_MAX = 4;

endpackage

// File: rtl/dm_arb_sel.sv
// Pipe/host winner select with a starvation counter that forces the host in
// after PIPE_BURST_MAX pipe grants taken while the host was waiting.
module dm_arb_sel
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned PIPE_BURST_MAX = DM_PIPE_BURST_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arbEn,
  input  logic pipeReq,
  input  logic hostReq,
  output logic pipeWin_c,
  output logic hostWin_c
);

  localparam int unsigned CNT_W = $clog2(PIPE_BURST_MAX + 1);

  logic [CNT_W-1:0] starveCnt;
  logic             starved;

  assign starved   = (starveCnt == CNT_W'(PIPE_BURST_MAX));
  assign hostWin_c = hostReq & (~pipeReq | starved);
  assign pipeWin_c = pipeReq & ~hostWin_c;

  // Counts pipe grants only while the host is actually waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt <= '0;
    end else if (!hostReq) begin
      starveCnt <= '0;
    end else if (arbEn && hostWin_c) begin
      starveCnt <= '0;
    end else if (arbEn && pipeWin_c && !starved) begin
      starveCnt <= starveCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Single-port data-memory sequencer shared by the MEM stage and a host port,
// one access outstanding, variable DM latency via dm_ready_i.
module dm_access_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DM_ADDR_WIDTH,
  parameter int unsigned PIPE_BURST_MAX = DM_PIPE_BURST_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_rd_i,
  input  logic                  pipe_wr_i,
  input  logic [ADDR_WIDTH-1:0] pipe_addr_i,
  input  logic [DATA_WIDTH-1:0] pipe_wdata_i,
  output logic [DATA_WIDTH-1:0] pipe_rdata_o,
  output logic                  pipe_rvalid_o,
  output logic                  stall_MEM_WB_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  host_rvalid_o,
  output logic                  dm_rd_o,
  output logic                  dm_wr_o,
  output logic [ADDR_WIDTH-1:0] dm_addr_o,
  output logic [DATA_WIDTH-1:0] dm_wdata_o,
  input  logic [DATA_WIDTH-1:0] dm_rdata_i,
  input  logic                  dm_ready_i
);

  dmState_e state;
  logic     pipeReq;
  logic     pipeWin;
  logic     hostWin;

  assign pipeReq = pipe_rd_i | pipe_wr_i;

  // Released in the completion cycle so WB can consume pipe_rdata_o next cycle.
  assign stall_MEM_WB_o = pipeReq & ~((state == PIPE_BUSY) & dm_ready_i);

  dm_arb_sel #(
    .PIPE_BURST_MAX(PIPE_BURST_MAX)
  ) uArbSel (
    .clk      (clk),
    .rst_n    (rst_n),
    .arbEn    (state == IDLE),
    .pipeReq  (pipeReq),
    .hostReq  (host_req_i),
    .pipeWin_c(pipeWin),
    .hostWin_c(hostWin)
  );

  // Grant/issue in IDLE, hold strobes while busy, capture read data on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      dm_rd_o       <= 1'b0;
      dm_wr_o       <= 1'b0;
      dm_addr_o     <= '0;
      dm_wdata_o    <= '0;
      host_gnt_o    <= 1'b0;
      pipe_rvalid_o <= 1'b0;
      host_rvalid_o <= 1'b0;
      pipe_rdata_o  <= '0;
      host_rdata_o  <= '0;
    end else begin
      host_gnt_o    <= 1'b0;
      pipe_rvalid_o <= 1'b0;
      host_rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (hostWin) begin
            state      <= HOST_BUSY;
            host_gnt_o <= 1'b1;
            dm_wr_o    <= host_we_i;
            dm_rd_o    <= ~host_we_i;
            dm_addr_o  <= host_addr_i;
            dm_wdata_o <= host_wdata_i;
          end else if (pipeWin) begin
            // A simultaneous read and write request is issued as a write.
            state      <= PIPE_BUSY;
            dm_wr_o    <= pipe_wr_i;
            dm_rd_o    <= ~pipe_wr_i;
            dm_addr_o  <= pipe_addr_i;
            dm_wdata_o <= pipe_wdata_i;
          end
        end
        PIPE_BUSY, HOST_BUSY: begin
          if (dm_ready_i) begin
            state   <= IDLE;
            dm_rd_o <= 1'b0;
            dm_wr_o <= 1'b0;
            if (dm_rd_o) begin
              if (state == PIPE_BUSY) begin
                pipe_rdata_o  <= dm_rdata_i;
                pipe_rvalid_o <= 1'b1;
              end else begin
                host_rdata_o  <= dm_rdata_i;
                host_rvalid_o <= 1'b1;
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          dm_rd_o <= 1'b0;
          dm_wr_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: pipe/host reads and writes, arbitration
// fairness, read+write collision, idle ready pulses and mid-access reset.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_rd_i = 1'b0;
  logic        pipe_wr_i = 1'b0;
  logic [7:0]  pipe_addr_i = '0;
  logic [15:0] pipe_wdata_i = '0;
  logic [15:0] pipe_rdata_o;
  logic        pipe_rvalid_o;
  logic        stall_MEM_WB_o;
  logic        host_req_i = 1'b0;
  logic        host_we_i = 1'b0;
  logic [7:0]  host_addr_i = '0;
  logic [15:0] host_wdata_i = '0;
  logic        host_gnt_o;
  logic [15:0] host_rdata_o;
  logic        host_rvalid_o;
  logic        dm_rd_o;
  logic        dm_wr_o;
  logic [7:0]  dm_addr_o;
  logic [15:0] dm_wdata_o;
  logic [15:0] dm_rdata_i = '0;
  logic        dm_ready_i;

  logic autoRdy = 1'b0;
  logic manRdy  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  // Auto mode answers every access in its first busy cycle.
  assign dm_ready_i = autoRdy ? (dm_rd_o | dm_wr_o) : manRdy;

  always #5 clk = ~clk;

  dm_access_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pipe_rd_i     (pipe_rd_i),
    .pipe_wr_i     (pipe_wr_i),
    .pipe_addr_i   (pipe_addr_i),
    .pipe_wdata_i  (pipe_wdata_i),
    .pipe_rdata_o  (pipe_rdata_o),
    .pipe_rvalid_o (pipe_rvalid_o),
    .stall_MEM_WB_o(stall_MEM_WB_o),
    .host_req_i    (host_req_i),
    .host_we_i     (host_we_i),
    .host_addr_i   (host_addr_i),
    .host_wdata_i  (host_wdata_i),
    .host_gnt_o    (host_gnt_o),
    .host_rdata_o  (host_rdata_o),
    .host_rvalid_o (host_rvalid_o),
    .dm_rd_o       (dm_rd_o),
    .dm_wr_o       (dm_wr_o),
    .dm_addr_o     (dm_addr_o),
    .dm_wdata_o    (dm_wdata_o),
    .dm_rdata_i    (dm_rdata_i),
    .dm_ready_i    (dm_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_dm_rd", 32'(dm_rd_o), 32'd0);
    chk("rst_dm_wr", 32'(dm_wr_o), 32'd0);
    chk("rst_addr", 32'(dm_addr_o), 32'd0);
    chk("rst_gnt", 32'(host_gnt_o), 32'd0);
    chk("rst_prvalid", 32'(pipe_rvalid_o), 32'd0);
    chk("rst_prdata", 32'(pipe_rdata_o), 32'd0);
    chk("rst_stall", 32'(stall_MEM_WB_o), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: pipe load 8'h10, ready after two busy cycles
    pipe_rd_i   = 1'b1;
    pipe_addr_i = 8'h10;
    dm_rdata_i  = 16'hBEEF;
    #1;
    chk("t1_stall_grant", 32'(stall_MEM_WB_o), 32'd1);
    tick();
    chk("t1_rd_b1", 32'(dm_rd_o), 32'd1);
    chk("t1_wr_b1", 32'(dm_wr_o), 32'd0);
    chk("t1_addr", 32'(dm_addr_o), 32'h10);
    chk("t1_stall_b1", 32'(stall_MEM_WB_o), 32'd1);
    tick();
    chk("t1_rd_b2", 32'(dm_rd_o), 32'd1);
    chk("t1_stall_b2", 32'(stall_MEM_WB_o), 32'd1);
    tick();
    manRdy = 1'b1;
    #1;
    chk("t1_stall_rdy", 32'(stall_MEM_WB_o), 32'd0);
    chk("t1_rvalid_early", 32'(pipe_rvalid_o), 32'd0);
    tick();
    manRdy    = 1'b0;
    pipe_rd_i = 1'b0;
    chk("t1_rvalid", 32'(pipe_rvalid_o), 32'd1);
    chk("t1_rdata", 32'(pipe_rdata_o), 32'hBEEF);
    chk("t1_rd_off", 32'(dm_rd_o), 32'd0);
    tick();
    chk("t1_rvalid_off", 32'(pipe_rvalid_o), 32'd0);
    chk("t1_rdata_held", 32'(pipe_rdata_o), 32'hBEEF);

    // 2: host write 8'h20 = 16'h1234 with the pipe idle
    host_req_i   = 1'b1;
    host_we_i    = 1'b1;
    host_addr_i  = 8'h20;
    host_wdata_i = 16'h1234;
    tick();
    host_req_i = 1'b0;
    chk("t2_gnt", 32'(host_gnt_o), 32'd1);
    chk("t2_wr", 32'(dm_wr_o), 32'd1);
    chk("t2_rd", 32'(dm_rd_o), 32'd0);
    chk("t2_addr", 32'(dm_addr_o), 32'h20);
    chk("t2_wdata", 32'(dm_wdata_o), 32'h1234);
    chk("t2_stall", 32'(stall_MEM_WB_o), 32'd0);
    tick();
    chk("t2_gnt_pulse", 32'(host_gnt_o), 32'd0);
    chk("t2_wr_held", 32'(dm_wr_o), 32'd1);
    manRdy = 1'b1;
    tick();
    manRdy = 1'b0;
    chk("t2_wr_off", 32'(dm_wr_o), 32'd0);
    chk("t2_hrvalid", 32'(host_rvalid_o), 32'd0);

    // Host read 8'h21 answered in the first busy cycle
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = 8'h21;
    dm_rdata_i  = 16'h5A5A;
    tick();
    host_req_i = 1'b0;
    chk("hr_gnt", 32'(host_gnt_o), 32'd1);
    chk("hr_rd", 32'(dm_rd_o), 32'd1);
    manRdy = 1'b1;
    tick();
    manRdy = 1'b0;
    chk("hr_rvalid", 32'(host_rvalid_o), 32'd1);
    chk("hr_rdata", 32'(host_rdata_o), 32'h5A5A);
    chk("hr_prvalid", 32'(pipe_rvalid_o), 32'd0);
    chk("hr_prdata", 32'(pipe_rdata_o), 32'hBEEF);

    // 4: pipe read and write together is a write
    pipe_rd_i    = 1'b1;
    pipe_wr_i    = 1'b1;
    pipe_addr_i  = 8'h05;
    pipe_wdata_i = 16'h0F0F;
    tick();
    chk("t4_wr", 32'(dm_wr_o), 32'd1);
    chk("t4_rd", 32'(dm_rd_o), 32'd0);
    chk("t4_addr", 32'(dm_addr_o), 32'h05);
    chk("t4_wdata", 32'(dm_wdata_o), 32'h0F0F);
    manRdy = 1'b1;
    #1;
    chk("t4_stall_rdy", 32'(stall_MEM_WB_o), 32'd0);
    tick();
    manRdy    = 1'b0;
    pipe_rd_i = 1'b0;
    pipe_wr_i = 1'b0;
    chk("t4_prvalid", 32'(pipe_rvalid_o), 32'd0);
    chk("t4_prdata", 32'(pipe_rdata_o), 32'hBEEF);

    // 6: ready pulse while idle changes nothing
    dm_rdata_i = 16'hFFFF;
    manRdy     = 1'b1;
    tick();
    manRdy = 1'b0;
    chk("t6_rd", 32'(dm_rd_o), 32'd0);
    chk("t6_wr", 32'(dm_wr_o), 32'd0);
    chk("t6_prvalid", 32'(pipe_rvalid_o), 32'd0);
    chk("t6_hrvalid", 32'(host_rvalid_o), 32'd0);
    chk("t6_prdata", 32'(pipe_rdata_o), 32'hBEEF);
    chk("t6_hrdata", 32'(host_rdata_o), 32'h5A5A);

    // 3: both ports hammer; expect P,P,P,P,H repeating
    autoRdy     = 1'b1;
    dm_rdata_i  = 16'h3333;
    pipe_rd_i   = 1'b1;
    pipe_addr_i = 8'h30;
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = 8'h40;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t3_addr_%0d", i), 32'(dm_addr_o), (i % 5 == 4) ? 32'h40 : 32'h30);
      chk($sformatf("t3_gnt_%0d", i), 32'(host_gnt_o), (i % 5 == 4) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("t3_prv_%0d", i), 32'(pipe_rvalid_o), (i % 5 == 4) ? 32'd0 : 32'd1);
    end
    pipe_rd_i  = 1'b0;
    host_req_i = 1'b0;
    autoRdy    = 1'b0;
    chk("t3_prdata", 32'(pipe_rdata_o), 32'h3333);
    chk("t3_hrdata", 32'(host_rdata_o), 32'h3333);
    tick();

    // 5: reset during a pipe access
    pipe_rd_i   = 1'b1;
    pipe_addr_i = 8'h11;
    tick();
    chk("t5_rd_busy", 32'(dm_rd_o), 32'd1);
    #2;
    rst_n     = 1'b0;
    pipe_rd_i = 1'b0;
    #1;
    chk("t5_rd_async", 32'(dm_rd_o), 32'd0);
    chk("t5_addr_async", 32'(dm_addr_o), 32'd0);
    chk("t5_prdata_rst", 32'(pipe_rdata_o), 32'd0);
    tick();
    rst_n  = 1'b1;
    manRdy = 1'b1;
    tick();
    manRdy = 1'b0;
    chk("t5_prvalid", 32'(pipe_rvalid_o), 32'd0);
    chk("t5_rd_idle", 32'(dm_rd_o), 32'd0);
    tick();
    chk("t5_prvalid2", 32'(pipe_rvalid_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
